// File: rtl/axi_bus_monitor_if.sv
// axi_bus_monitor_if: the AXI4 handshake, burst-length and ID signals
// that axi_bus_monitor observes.
// The master and slave modports describe the two ends of the bus.
// The monitor modport is input-only, so the monitor cannot drive the bus.
interface axi_bus_monitor_if #(
    parameter int ID_W = 4
);
    logic            awvalid;
    logic            awready;
    logic            wvalid;
    logic            wready;
    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic            arvalid;
    logic            arready;
    logic [7:0]      arlen;
    logic            rvalid;
    logic            rready;
    logic            rlast;
    logic [ID_W-1:0] rid;

    modport master (
        output awvalid, wvalid, bready, arvalid, arlen, rready,
        input  awready, wready, bvalid, bid, arready, rvalid, rlast, rid
    );

    modport slave (
        input  awvalid, wvalid, bready, arvalid, arlen, rready,
        output awready, wready, bvalid, bid, arready, rvalid, rlast, rid
    );

    modport monitor (
        input awvalid, awready, wvalid, wready, bvalid, bready, bid,
              arvalid, arready, arlen, rvalid, rready, rlast, rid
    );
endinterface

// File: rtl/axi_bus_monitor.sv
// axi_bus_monitor: passive AXI4 monitor. It counts handshakes and commits,
// tracks outstanding read and write bursts, and checks each read burst
// length against the position of RLAST. It also flags channels whose
// valid has been held without ready for too long.
// Optional build macro: AXI_MON_DISPLAY_EN prints handshakes and flag
// rising edges. Counter and flag behaviour is the same with or without it.
module axi_bus_monitor #(
    parameter int ID_W        = 4,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 100,
    parameter int RD_DEPTH    = 8,
    parameter int WR_MAX      = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    axi_bus_monitor_if.monitor            axi,
    input  logic                          commit,
    output logic [CNT_W-1:0]              cnt_cycle,
    output logic [CNT_W-1:0]              cnt_aw,
    output logic [CNT_W-1:0]              cnt_w,
    output logic [CNT_W-1:0]              cnt_b,
    output logic [CNT_W-1:0]              cnt_ar,
    output logic [CNT_W-1:0]              cnt_r,
    output logic [CNT_W-1:0]              cnt_commit,
    output logic [$clog2(RD_DEPTH):0]     rd_outstanding,
    output logic [$clog2(WR_MAX+1)-1:0]   wr_outstanding,
    output logic [4:0]                    stall_flag,
    output logic [3:0]                    err_flag
);
    localparam int RD_AW = $clog2(RD_DEPTH);
    localparam int WR_W  = $clog2(WR_MAX + 1);
    localparam int SW    = $clog2(STALL_LIMIT + 1);

    localparam logic [RD_AW:0]   RD_FULL = (RD_AW + 1)'(RD_DEPTH);
    localparam logic [WR_W-1:0]  WR_TOP  = WR_W'(WR_MAX);
    localparam logic [SW-1:0]    ST_LIM  = SW'(STALL_LIMIT);

    // Saturating event counter step: stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // Stall counter step: counts consecutive stalled cycles up to the limit.
    function automatic logic [SW-1:0] stall_next(input logic [SW-1:0] v,
                                                 input logic stalled);
        if (!stalled)
            return '0;
        if (v == ST_LIM)
            return v;
        return v + SW'(1);
    endfunction

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid  && axi.wready;
    assign b_hs  = axi.bvalid  && axi.bready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign r_hs  = axi.rvalid  && axi.rready;

    // The IDs are observed for debug only and never checked.
    logic [ID_W-1:0] unused_ids;
    assign unused_ids = axi.rid ^ axi.bid;

    // Event counters. Clear takes priority over an event in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_cycle  <= '0;
            cnt_aw     <= '0;
            cnt_w      <= '0;
            cnt_b      <= '0;
            cnt_ar     <= '0;
            cnt_r      <= '0;
            cnt_commit <= '0;
        end else begin
            cnt_cycle  <= sat_inc(cnt_cycle, 1'b1);
            cnt_aw     <= sat_inc(cnt_aw, aw_hs);
            cnt_w      <= sat_inc(cnt_w, w_hs);
            cnt_b      <= sat_inc(cnt_b, b_hs);
            cnt_ar     <= sat_inc(cnt_ar, ar_hs);
            cnt_r      <= sat_inc(cnt_r, r_hs);
            cnt_commit <= sat_inc(cnt_commit, commit);
        end
    end

    logic [7:0]       rd_len [RD_DEPTH];
    logic [RD_AW-1:0] rd_wptr, rd_rptr;
    logic [7:0]       beat;
    logic             rd_full, rd_empty, rd_push, rd_pop, rd_beat, beat_last;
    logic             rlast_err;
    logic [3:0]       err_set;

    // Read tracker control and error detection. The FIFO does not forward:
    // an R beat in the same cycle as the first AR sees an empty tracker.
    always_comb begin
        rd_full   = (rd_outstanding == RD_FULL);
        rd_empty  = (rd_outstanding == '0);
        beat_last = (beat == rd_len[rd_rptr]);
        rd_push   = ar_hs && !rd_full;
        rd_beat   = r_hs && !rd_empty;
        rd_pop    = rd_beat && (beat_last || axi.rlast);
        rlast_err = rd_beat && (beat_last != axi.rlast);
        err_set    = '0;
        err_set[0] = r_hs && rd_empty;
        err_set[1] = rlast_err;
        err_set[2] = ar_hs && rd_full;
        err_set[3] = b_hs && !aw_hs && (wr_outstanding == '0);
    end

    // Burst-length storage. It is data only and needs no reset.
    always_ff @(posedge clock) begin
        if (rd_push)
            rd_len[rd_wptr] <= axi.arlen;
    end

    // Read tracker pointers, occupancy and beat counter. An RLAST mismatch
    // still pops the burst, so the tracker resynchronises to the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_wptr        <= '0;
            rd_rptr        <= '0;
            rd_outstanding <= '0;
            beat           <= '0;
        end else begin
            if (rd_push)
                rd_wptr <= rd_wptr + RD_AW'(1);
            if (rd_pop)
                rd_rptr <= rd_rptr + RD_AW'(1);
            case ({rd_push, rd_pop})
                2'b10:   rd_outstanding <= rd_outstanding + (RD_AW + 1)'(1);
                2'b01:   rd_outstanding <= rd_outstanding - (RD_AW + 1)'(1);
                default: rd_outstanding <= rd_outstanding;
            endcase
            if (rd_beat)
                beat <= rd_pop ? 8'd0 : beat + 8'd1;
        end
    end

    // Write tracker: AW adds a burst and B retires one. A simultaneous AW
    // and B cancel out. The count saturates at WR_MAX and floors at zero.
    always_ff @(posedge clock) begin
        if (reset)
            wr_outstanding <= '0;
        else if (aw_hs && !b_hs && (wr_outstanding != WR_TOP))
            wr_outstanding <= wr_outstanding + WR_W'(1);
        else if (b_hs && !aw_hs && (wr_outstanding != '0))
            wr_outstanding <= wr_outstanding - WR_W'(1);
    end

    logic [4:0]    ch_stalled;
    logic [4:0]    stall_set;
    logic [SW-1:0] stall_cnt [5];

    // Per-channel stall condition. The flag fires on the cycle whose count
    // reaches STALL_LIMIT, so it becomes visible one cycle later.
    always_comb begin
        ch_stalled = {axi.rvalid  && !axi.rready,
                      axi.arvalid && !axi.arready,
                      axi.bvalid  && !axi.bready,
                      axi.wvalid  && !axi.wready,
                      axi.awvalid && !axi.awready};
        stall_set = '0;
        for (int i = 0; i < 5; i++)
            stall_set[i] = (stall_next(stall_cnt[i], ch_stalled[i]) == ST_LIM);
    end

    // Stall counters follow live bus state. Clear does not touch them.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 5; i++)
                stall_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++)
                stall_cnt[i] <= stall_next(stall_cnt[i], ch_stalled[i]);
        end
    end

    // Sticky flags. Clear takes priority over a flag being set that cycle.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            err_flag   <= '0;
            stall_flag <= '0;
        end else begin
            err_flag   <= err_flag | err_set;
            stall_flag <= stall_flag | stall_set;
        end
    end

`ifdef AXI_MON_DISPLAY_EN
    // Trace of read traffic and of every rising edge of a sticky flag.
    always @(posedge clock) begin
        if (!reset) begin
            if (ar_hs)
                $display("[axi_mon] cycle %0d AR arlen=%0d", cnt_cycle, axi.arlen);
            if (r_hs)
                $display("[axi_mon] cycle %0d R rid=%0h rlast=%0b",
                         cnt_cycle, axi.rid, axi.rlast);
            for (int i = 0; i < 4; i++)
                if (err_set[i] && !err_flag[i] && !clear)
                    $display("[axi_mon] cycle %0d error flag %0d raised", cnt_cycle, i);
            for (int i = 0; i < 5; i++)
                if (stall_set[i] && !stall_flag[i] && !clear)
                    $display("[axi_mon] cycle %0d stall flag %0d raised", cnt_cycle, i);
        end
    end
`else
    // Default build: no reporting logic. The design is fully synthesisable.
`endif

endmodule

// File: tb/tb_axi_bus_monitor.sv
// tb_axi_bus_monitor: directed bench for axi_bus_monitor. A default
// instance and a CNT_W=4 instance observe the same bus.
module tb_axi_bus_monitor;
    localparam int ID_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic commit = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    axi_bus_monitor_if #(.ID_W(ID_W)) axi ();

    logic [31:0] cnt_cycle, cnt_aw, cnt_w, cnt_b, cnt_ar, cnt_r, cnt_commit;
    logic [3:0]  rd_outstanding;
    logic [3:0]  wr_outstanding;
    logic [4:0]  stall_flag;
    logic [3:0]  err_flag;

    logic [3:0]  s_cycle, s_aw, s_w, s_b, s_ar, s_r, s_commit;
    logic [3:0]  s_rd_out;
    logic [3:0]  s_wr_out;
    logic [4:0]  s_stall;
    logic [3:0]  s_err;

    axi_bus_monitor #(.ID_W(ID_W)) dut (
        .clock(clock), .reset(reset), .clear(clear), .axi(axi), .commit(commit),
        .cnt_cycle(cnt_cycle), .cnt_aw(cnt_aw), .cnt_w(cnt_w), .cnt_b(cnt_b),
        .cnt_ar(cnt_ar), .cnt_r(cnt_r), .cnt_commit(cnt_commit),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .stall_flag(stall_flag), .err_flag(err_flag)
    );

    axi_bus_monitor #(.ID_W(ID_W), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .clear(clear), .axi(axi), .commit(commit),
        .cnt_cycle(s_cycle), .cnt_aw(s_aw), .cnt_w(s_w), .cnt_b(s_b),
        .cnt_ar(s_ar), .cnt_r(s_r), .cnt_commit(s_commit),
        .rd_outstanding(s_rd_out), .wr_outstanding(s_wr_out),
        .stall_flag(s_stall), .err_flag(s_err)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        axi.awvalid = 0; axi.awready = 0; axi.wvalid = 0; axi.wready = 0;
        axi.bvalid = 0; axi.bready = 0; axi.bid = '0;
        axi.arvalid = 0; axi.arready = 0; axi.arlen = 8'd0;
        axi.rvalid = 0; axi.rready = 0; axi.rlast = 0; axi.rid = '0;

        // Reset for 2 cycles, then idle for 10 cycles.
        step(2);
        chk("reset_cycle", 64'(cnt_cycle), 64'd0);
        chk("reset_rd_out", 64'(rd_outstanding), 64'd0);
        chk("reset_err", 64'(err_flag), 64'd0);
        reset = 0;
        step(10);
        chk("idle_cycle", 64'(cnt_cycle), 64'd10);
        chk("idle_ar", 64'(cnt_ar), 64'd0);
        chk("idle_commit", 64'(cnt_commit), 64'd0);
        chk("idle_stall", 64'(stall_flag), 64'd0);
        chk("idle_wr_out", 64'(wr_outstanding), 64'd0);

        // AR with arlen=3, then 4 R beats with RLAST on the fourth.
        axi.arvalid = 1; axi.arready = 1; axi.arlen = 8'd3;
        step(1);
        axi.arvalid = 0; axi.arready = 0;
        chk("ar1_cnt", 64'(cnt_ar), 64'd1);
        chk("ar1_rd_out", 64'(rd_outstanding), 64'd1);
        axi.rvalid = 1; axi.rready = 1; axi.rlast = 0;
        step(3);
        chk("burst_mid_rd_out", 64'(rd_outstanding), 64'd1);
        axi.rlast = 1;
        step(1);
        axi.rvalid = 0; axi.rready = 0; axi.rlast = 0;
        chk("burst_cnt_r", 64'(cnt_r), 64'd4);
        chk("burst_rd_out", 64'(rd_outstanding), 64'd0);
        chk("burst_err", 64'(err_flag), 64'd0);

        // AR with arlen=1 ended early by RLAST on its first beat.
        axi.arvalid = 1; axi.arready = 1; axi.arlen = 8'd1;
        step(1);
        axi.arvalid = 0; axi.arready = 0;
        axi.rvalid = 1; axi.rready = 1; axi.rlast = 1;
        step(1);
        axi.rvalid = 0; axi.rready = 0; axi.rlast = 0;
        chk("short_err", 64'(err_flag), 64'b0010);
        chk("short_rd_out", 64'(rd_outstanding), 64'd0);
        chk("short_cnt_r", 64'(cnt_r), 64'd5);

        // Clear coincides with a commit, so the commit must not count.
        clear = 1; commit = 1;
        step(1);
        clear = 0; commit = 0;
        chk("clear_err", 64'(err_flag), 64'd0);
        chk("clear_ar", 64'(cnt_ar), 64'd0);
        chk("clear_commit", 64'(cnt_commit), 64'd0);
        chk("clear_cycle", 64'(cnt_cycle), 64'd0);
        step(1);
        chk("post_clear_cycle", 64'(cnt_cycle), 64'd1);

        // RD_DEPTH+1 ARs with no R overflow the read tracker.
        axi.arvalid = 1; axi.arready = 1; axi.arlen = 8'd0;
        step(9);
        axi.arvalid = 0; axi.arready = 0;
        chk("full_rd_out", 64'(rd_outstanding), 64'd8);
        chk("full_err", 64'(err_flag), 64'b0100);
        chk("full_cnt_ar", 64'(cnt_ar), 64'd9);

        // A lone B with no AW outstanding.
        axi.bvalid = 1; axi.bready = 1;
        step(1);
        axi.bvalid = 0; axi.bready = 0;
        chk("lone_b_err", 64'(err_flag), 64'b1100);
        chk("lone_b_wr_out", 64'(wr_outstanding), 64'd0);
        chk("lone_b_cnt", 64'(cnt_b), 64'd1);

        // Drain the 8 single-beat bursts, then send one extra R beat.
        axi.rvalid = 1; axi.rready = 1; axi.rlast = 1;
        step(8);
        chk("drain_rd_out", 64'(rd_outstanding), 64'd0);
        chk("drain_err", 64'(err_flag), 64'b1100);
        step(1);
        axi.rvalid = 0; axi.rready = 0; axi.rlast = 0;
        chk("extra_r_err", 64'(err_flag), 64'b1101);
        chk("extra_r_rd_out", 64'(rd_outstanding), 64'd0);
        clear = 1;
        step(1);
        clear = 0;

        // AR stalled for STALL_LIMIT-1 cycles and then accepted.
        axi.arvalid = 1; axi.arready = 0; axi.arlen = 8'd0;
        step(99);
        chk("stall99_flag", 64'(stall_flag), 64'd0);
        axi.arready = 1;
        step(1);
        axi.arvalid = 0; axi.arready = 0;
        chk("stall99_accept_flag", 64'(stall_flag), 64'd0);

        // AR stalled for exactly STALL_LIMIT cycles.
        axi.arvalid = 1; axi.arready = 0;
        step(99);
        chk("stall100_pre_flag", 64'(stall_flag), 64'd0);
        step(1);
        chk("stall100_flag", 64'(stall_flag), 64'b01000);
        chk("stall100_flag4", 64'(s_stall), 64'b01000);
        axi.arvalid = 0;
        clear = 1;
        step(1);
        clear = 0;
        chk("stall_clear", 64'(stall_flag), 64'd0);

        // 20 commits: the CNT_W=4 instance saturates at 15.
        commit = 1;
        step(20);
        commit = 0;
        chk("commit_wide", 64'(cnt_commit), 64'd20);
        chk("commit_sat4", 64'(s_commit), 64'd15);
        chk("cycle_sat4", 64'(s_cycle), 64'd15);

        // W handshakes, then the write tracker.
        axi.wvalid = 1; axi.wready = 1;
        step(3);
        axi.wvalid = 0; axi.wready = 0;
        chk("w_cnt", 64'(cnt_w), 64'd3);
        axi.awvalid = 1; axi.awready = 1;
        step(2);
        chk("aw2_wr_out", 64'(wr_outstanding), 64'd2);
        axi.bvalid = 1; axi.bready = 1;
        step(1);
        chk("aw_b_same_wr_out", 64'(wr_outstanding), 64'd2);
        axi.awvalid = 0; axi.awready = 0;
        step(1);
        axi.bvalid = 0; axi.bready = 0;
        chk("b_wr_out", 64'(wr_outstanding), 64'd1);
        chk("aw_cnt", 64'(cnt_aw), 64'd3);
        axi.awvalid = 1; axi.awready = 1;
        step(20);
        axi.awvalid = 0; axi.awready = 0;
        chk("aw_sat_wr_out", 64'(wr_outstanding), 64'd15);
        chk("aw_sat_err", 64'(err_flag), 64'd0);

        // Reset empties the trackers.
        reset = 1;
        step(1);
        reset = 0;
        chk("reset2_wr_out", 64'(wr_outstanding), 64'd0);
        chk("reset2_rd_out", 64'(rd_outstanding), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
